// File: rtl/gray_seq_param.sv
// rtl/gray_seq_param.sv - parametrised Gray-coded state sequencer with command handshake
module gray_seq_param #(
  parameter int STATE_W = 4,
  parameter int OUT_W   = 8,
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [1:0]         cmd_op,
  input  logic [STATE_W-1:0] cmd_arg,
  input  logic [DWELL_W-1:0] cmd_dwell,
  output logic [STATE_W-1:0] state_gray,
  output logic [OUT_W-1:0]   out,
  output logic               wrap
);

  localparam int SEL_W = $clog2(OUT_W);

  localparam logic [1:0] OP_HOLD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DN   = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  localparam logic [STATE_W-1:0] IDX_MAX = '1;
  localparam logic [STATE_W-1:0] IDX_ONE = STATE_W'(1);
  localparam logic [DWELL_W-1:0] CNT_ONE = DWELL_W'(1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_DWELL = 1'b1
  } ctl_state_t;

  ctl_state_t         state_q, state_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [STATE_W-1:0] idx_q, idx_d;
  logic               wrap_d;
  logic               accept;

  function automatic logic [STATE_W-1:0] gray2bin(input logic [STATE_W-1:0] g);
    logic [STATE_W-1:0] b;
    b[STATE_W-1] = g[STATE_W-1];
    for (int i = STATE_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign accept = cmd_valid & cmd_ready;

  // State register: FSM, dwell counter, index and the registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      state_gray <= '0;
      wrap       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      state_gray <= idx_d ^ (idx_d >> 1);
      wrap       <= wrap_d;
    end
  end

  // Index update; wrap only on a STEP crossing the sequence end.
  always_comb begin
    idx_d  = idx_q;
    wrap_d = 1'b0;
    if (accept) begin
      case (cmd_op)
        OP_UP: begin
          idx_d  = idx_q + IDX_ONE;
          wrap_d = (idx_q == IDX_MAX);
        end
        OP_DN: begin
          idx_d  = idx_q - IDX_ONE;
          wrap_d = (idx_q == '0);
        end
        OP_LOAD: idx_d = gray2bin(cmd_arg);
        default: idx_d = idx_q;
      endcase
    end
  end

  // Next-state logic; HOLD never stalls.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (cmd_op != OP_HOLD) && (cmd_dwell != '0)) begin
          state_d = S_DWELL;
          cnt_d   = cmd_dwell;
        end
      end
      S_DWELL: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from registered state only.
  always_comb begin
    cmd_ready = (state_q == S_IDLE);
    out       = '0;
    out[idx_q[SEL_W-1:0]] = 1'b1;
  end

endmodule

// File: tb/tb_gray_seq_param.sv
// tb/tb_gray_seq_param.sv - scoreboard bench for gray_seq_param with random commands
module tb_gray_seq_param;

  localparam int STATE_W = 4;
  localparam int OUT_W   = 8;
  localparam int DWELL_W = 4;
  localparam int NSTATES = 1 << STATE_W;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [1:0]         cmd_op;
  logic [STATE_W-1:0] cmd_arg;
  logic [DWELL_W-1:0] cmd_dwell;
  logic [STATE_W-1:0] state_gray;
  logic [OUT_W-1:0]   out;
  logic               wrap;

  gray_seq_param #(.STATE_W(STATE_W), .OUT_W(OUT_W), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_arg(cmd_arg), .cmd_dwell(cmd_dwell),
    .state_gray(state_gray), .out(out), .wrap(wrap)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [STATE_W-1:0] gray;
    logic [OUT_W-1:0]   onehot;
    logic               wrap;
    logic               ready;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: integer position plus remaining stall cycles.
  int m_idx   = 0;
  int m_stall = 0;
  bit m_wrap  = 0;
  bit m_acc   = 0;

  function automatic int g2b(int g);
    int b = 0;
    for (int s = 0; s < STATE_W; s++) b = b ^ (g >> s);
    return b % NSTATES;
  endfunction

  task automatic check(string name, int act, int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // One clock: advance the model on the edge and queue what the DUT should show.
  task automatic cycle();
    bit   rdy;
    exp_t e;
    rdy   = (m_stall == 0);
    m_acc = 0;
    @(posedge clk);
    m_wrap = 0;
    if (!rst_n) begin
      m_idx   = 0;
      m_stall = 0;
    end else if (cmd_valid && rdy) begin
      m_acc = 1;
      case (cmd_op)
        2'b01: begin m_wrap = (m_idx == NSTATES - 1); m_idx = (m_idx + 1) % NSTATES; end
        2'b10: begin m_wrap = (m_idx == 0); m_idx = (m_idx + NSTATES - 1) % NSTATES; end
        2'b11: m_idx = g2b(int'(cmd_arg));
        default: ;
      endcase
      m_stall = (cmd_op == 2'b00) ? 0 : int'(cmd_dwell);
    end else if (m_stall > 0) begin
      m_stall--;
    end
    e.gray   = STATE_W'(m_idx ^ (m_idx >> 1));
    e.onehot = OUT_W'(1) << (m_idx % OUT_W);
    e.wrap   = m_wrap;
    e.ready  = (m_stall == 0);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input int arg, input int dwell);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = STATE_W'(arg);
    cmd_dwell = DWELL_W'(dwell);
    do begin
      cycle();
      n++;
    end while (!m_acc && n < 64);
    if (!m_acc) check("accept_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_arg   = STATE_W'($urandom);
      cmd_dwell = DWELL_W'($urandom);
      cycle();
    end
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    for (int i = 0; i < n; i++) begin
      cmd_valid = 1'($urandom);
      cmd_op    = 2'($urandom_range(1, 3));
      cmd_arg   = STATE_W'($urandom);
      cmd_dwell = DWELL_W'($urandom);
      cycle();
    end
    rst_n = 1'b1;
  endtask

  // Monitor: compares the DUT against the oldest queued expectation each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("state_gray", int'(state_gray), int'(e.gray));
        check("out", int'(out), int'(e.onehot));
        check("wrap", int'(wrap), int'(e.wrap));
        check("cmd_ready", int'(cmd_ready), int'(e.ready));
      end
    end
  end

  initial begin
    int r;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_arg   = '0;
    cmd_dwell = '0;
    do_reset(2);
    idle(1);
    for (int i = 0; i < NSTATES; i++) issue(2'b01, 0, 0);
    do_reset(1);
    issue(2'b10, 0, 0);
    issue(2'b11, 4'b1111, 3);
    issue(2'b01, 0, 0);
    idle(1);
    issue(2'b01, 0, 7);
    idle(1);
    do_reset(1);
    idle(1);
    issue(2'b00, 0, 5);
    issue(2'b01, 0, 0);
    idle(2);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) do_reset($urandom_range(1, 2));
      else if (r < 15) idle($urandom_range(1, 3));
      else issue(2'($urandom), $urandom, (r < 25) ? $urandom_range(0, 15) : $urandom_range(0, 2));
    end
    idle(2);
    @(negedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
